hd_enc_sched: RTL and testbench

HD_ENC_SCHED -- requirements
Module: hd_enc_sched

---
 rtl/hd_enc_sched_pkg.sv | 14 +
 rtl/hd_enc_sched_rr_arb2.sv | 16 +
 rtl/hd_enc_sched.sv | 134 +++++++++++++
 tb/tb_hd_enc_sched.sv | 593 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_enc_sched_pkg.sv
// Shared widths and FSM encodings for the Hamming encoder scheduler.
package hd_enc_sched_pkg;

    localparam int unsigned HD_DATA_W  = 4;
    localparam int unsigned HD_CODE_W  = 7;
    localparam int unsigned HD_TIMEOUT = 8;
    localparam int unsigned HD_CNT_W   = 8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

endpackage

// File: rtl/hd_enc_sched_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, contention goes to
// the requester that was not served last.
module hd_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/hd_enc_sched.sv
// Arbitrates two requesters onto one shared Hamming encoder and returns each
// codeword to its owner, aborting a word whose result never arrives.
module hd_enc_sched
    import hd_enc_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = HD_DATA_W,
    parameter int unsigned CODE_W  = HD_CODE_W,
    parameter int unsigned TIMEOUT = HD_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              enc_valid,
    output logic [DATA_W-1:0] enc_data,
    input  logic              enc_code_valid,
    input  logic [CODE_W-1:0] enc_code,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [CODE_W-1:0] rsp_code,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [HD_CNT_W-1:0] TimeoutLast = HD_CNT_W'(TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                id_q, id_d;
    logic                rsp_id_q, rsp_id_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [HD_CNT_W-1:0] cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic       idle;
    logic [1:0] req_vec;
    logic [1:0] gnt;
    logic [1:0] ready;

    assign idle    = (state_q == StIdle);
    assign req_vec = {req1_valid, req0_valid};

    hd_rr_arb2 u_arb (
        .req  (req_vec),
        .last (last_q),
        .gnt  (gnt)
    );

    // rst gates the readys so nothing is offered while reset is held in IDLE.
    assign ready = (idle && rst) ? gnt : 2'b00;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (|ready) begin
                    data_d  = ready[1] ? req1_data : req0_data;
                    id_d    = ready[1];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A result arriving on the final count still wins over the abort.
                if (enc_code_valid) begin
                    code_d   = enc_code;
                    rsp_id_d = id_q;
                    state_d  = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + HD_CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    last_d  = rsp_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            code_q   <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign enc_valid   = (state_q == StIssue);
    assign enc_data    = data_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = rsp_id_q;
    assign rsp_code    = code_q;
    assign busy        = !idle;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hd_enc_sched.sv
// Bench for hd_enc_sched: directed scenarios plus randomized traffic checked
// against a round-robin / Hamming(7,4) reference model.
module tb_hd_enc_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       enc_valid;
    logic [3:0] enc_data;
    logic       enc_code_valid;
    logic [6:0] enc_code;
    logic       rsp_valid, rsp_id;
    logic [6:0] rsp_code;
    logic       rsp_ready, busy, err_timeout;

    always #5 clk = ~clk;

    hd_enc_sched #(
        .DATA_W  (4),
        .CODE_W  (7),
        .TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .enc_valid      (enc_valid),
        .enc_data       (enc_data),
        .enc_code_valid (enc_code_valid),
        .enc_code       (enc_code),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_code       (rsp_code),
        .rsp_ready      (rsp_ready),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    // Encoder model: 0 silent, 1 fixed code, 2 Hamming(7,4) of enc_data.
    int         enc_mode;
    int         enc_delay;
    int         enc_rand;
    logic [6:0] enc_fixed;
    int         pend;
    logic [6:0] pend_code;

    logic [3:0] words0[$], words1[$];
    logic [1:0] acc_mask[$], acc_gnt[$];
    logic       obs_id[$];
    logic [6:0] obs_code[$];
    int         err_cnt;
    int         rdy_pct;
    int         gap_en;
    logic       vld0, vld1;

    function automatic logic [6:0] ham(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    initial begin
        enc_code_valid = 1'b0;
        enc_code       = '0;
        pend           = 0;
        pend_code      = '0;
        forever begin
            @(posedge clk);
            #1;
            enc_code_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    enc_code_valid = 1'b1;
                    enc_code       = pend_code;
                end
            end
            if (enc_valid && enc_mode != 0) begin
                pend      = (enc_rand != 0) ? int'($urandom_range(1, 3)) : enc_delay;
                pend_code = (enc_mode == 1) ? enc_fixed : ham(enc_data);
            end
        end
    end

    task automatic clear_logs;
        words0.delete();
        words1.delete();
        acc_mask.delete();
        acc_gnt.delete();
        obs_id.delete();
        obs_code.delete();
        err_cnt = 0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Requesters hold valid until accepted; optional random gaps before asserting.
    task automatic drive(input int nresp, input int budget, output int got, output int cycles);
        got    = 0;
        cycles = 0;
        vld0   = 1'b0;
        vld1   = 1'b0;
        while (got < nresp && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (!vld0 && words0.size() > 0 && (gap_en == 0 || $urandom_range(0, 1) == 1)) vld0 = 1'b1;
            if (!vld1 && words1.size() > 0 && (gap_en == 0 || $urandom_range(0, 1) == 1)) vld1 = 1'b1;
            req0_valid = vld0;
            req1_valid = vld1;
            if (vld0) req0_data = words0[0];
            if (vld1) req1_data = words1[0];
            rsp_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            #1;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_mask.push_back({req1_valid, req0_valid});
                acc_gnt.push_back({req1_ready, req0_ready});
                if (req0_valid && req0_ready) begin
                    void'(words0.pop_front());
                    vld0 = 1'b0;
                end
                if (req1_valid && req1_ready) begin
                    void'(words1.pop_front());
                    vld1 = 1'b0;
                end
            end
            if (rsp_valid && rsp_ready) begin
                obs_id.push_back(rsp_id);
                obs_code.push_back(rsp_code);
                got++;
            end
            if (err_timeout) err_cnt++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'hF;
        req1_data  = 4'hF;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({req0_ready, req1_ready, enc_valid, rsp_valid, busy, err_timeout, rsp_id} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {req0_ready, req1_ready, enc_valid, rsp_valid, busy, err_timeout, rsp_id});
        end
        vectors++;
        if (enc_data !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_enc_data: got %h expected 0", enc_data);
        end
        vectors++;
        if (rsp_code !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_rsp_code: got %h expected 00", rsp_code);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, first_rsp, ev_cnt;
        apply_reset();
        enc_mode   = 1;
        enc_fixed  = 7'h55;
        enc_delay  = 1;
        enc_rand   = 0;
        req0_valid = 1'b1;
        req0_data  = 4'hB;
        rsp_ready  = 1'b0;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        cyc       = 1;
        first_rsp = 0;
        ev_cnt    = 0;
        while (first_rsp == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req0_valid = 1'b0;
            #1;
            if (enc_valid) begin
                ev_cnt++;
                vectors++;
                if (enc_data !== 4'hB) begin
                    miscompares++;
                    $display("FAIL single_enc_data: got %h expected b", enc_data);
                end
            end
            if (rsp_valid) first_rsp = cyc;
        end
        vectors++;
        if (first_rsp !== 4) begin
            miscompares++;
            $display("FAIL single_latency: rsp in cycle %0d expected 4", first_rsp);
        end
        vectors++;
        if (ev_cnt !== 1) begin
            miscompares++;
            $display("FAIL single_enc_strobes: got %0d expected 1", ev_cnt);
        end
        vectors++;
        if (rsp_id !== 1'b0 || rsp_code !== 7'h55) begin
            miscompares++;
            $display("FAIL single_rsp: got id %b code %h expected id 0 code 55", rsp_id, rsp_code);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({busy, rsp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_done: got busy/rsp %b expected 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_contention;
        int got, cyc;
        apply_reset();
        clear_logs();
        words0.push_back(4'h3);
        words1.push_back(4'hC);
        gap_en    = 0;
        rdy_pct   = 100;
        enc_mode  = 2;
        enc_delay = 1;
        enc_rand  = 0;
        drive(2, 40, got, cyc);
        vectors++;
        if (got !== 2) begin
            miscompares++;
            $display("FAIL contention_count: got %0d expected 2", got);
        end
        if (obs_id.size() >= 2) begin
            vectors++;
            if ({obs_id[0], obs_id[1]} !== 2'b01) begin
                miscompares++;
                $display("FAIL contention_order: got %b,%b expected 0,1", obs_id[0], obs_id[1]);
            end
            vectors++;
            if (obs_code[0] !== ham(4'h3) || obs_code[1] !== ham(4'hC)) begin
                miscompares++;
                $display("FAIL contention_codes: got %h,%h expected %h,%h",
                         obs_code[0], obs_code[1], ham(4'h3), ham(4'hC));
            end
        end
    endtask

    task automatic test_sustained;
        int got, cyc;
        logic [3:0] m0[$], m1[$];
        apply_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            words0.push_back(4'($urandom));
            words1.push_back(4'($urandom));
        end
        m0        = words0;
        m1        = words1;
        gap_en    = 0;
        rdy_pct   = 100;
        enc_mode  = 2;
        enc_delay = 1;
        enc_rand  = 0;
        drive(6, 100, got, cyc);
        vectors++;
        if (got !== 6 || cyc !== 24) begin
            miscompares++;
            $display("FAIL sustained_rate: got %0d words in %0d cycles expected 6 in 24", got, cyc);
        end
        for (int k = 0; k < 6 && k < obs_id.size(); k++) begin
            vectors++;
            if (obs_id[k] !== 1'(k % 2) ||
                obs_code[k] !== ham((k % 2 == 0) ? m0[k / 2] : m1[k / 2])) begin
                miscompares++;
                $display("FAIL sustained_rsp%0d: got id %b code %h expected id %0d code %h", k,
                         obs_id[k], obs_code[k], k % 2,
                         ham((k % 2 == 0) ? m0[k / 2] : m1[k / 2]));
            end
        end
    endtask

    // mode 0 = silent encoder; otherwise Hamming result after dly cycles.
    task automatic test_timeout(input int mode, input int dly, input bit exp_rsp);
        int cyc, issue_cyc, err_first, err_n, rsp_first, rsp_n;
        logic busy_at_err, busy_last_wait;
        apply_reset();
        enc_mode   = mode;
        enc_delay  = dly;
        enc_rand   = 0;
        req0_valid = 1'b1;
        req0_data  = 4'hA;
        rsp_ready  = 1'b1;
        cyc        = 1;
        issue_cyc  = 0;
        err_first  = 0;
        err_n      = 0;
        rsp_first  = 0;
        rsp_n      = 0;
        busy_at_err    = 1'b1;
        busy_last_wait = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            req0_valid = 1'b0;
            #1;
            if (enc_valid) issue_cyc = cyc;
            if (err_timeout) begin
                err_n++;
                if (err_first == 0) begin
                    err_first   = cyc;
                    busy_at_err = busy;
                end
            end
            if (rsp_valid) begin
                rsp_n++;
                if (rsp_first == 0) rsp_first = cyc;
            end
            if (issue_cyc != 0 && cyc == issue_cyc + 8) busy_last_wait = busy;
        end
        vectors++;
        if (issue_cyc !== 2) begin
            miscompares++;
            $display("FAIL timeout_issue_cycle: got %0d expected 2", issue_cyc);
        end
        if (exp_rsp) begin
            vectors++;
            if (err_n !== 0 || rsp_n !== 1 || rsp_first !== 11) begin
                miscompares++;
                $display("FAIL timeout_race: got err %0d rsp %0d at %0d expected err 0 rsp 1 at 11",
                         err_n, rsp_n, rsp_first);
            end
        end else begin
            vectors++;
            if (err_n !== 1 || err_first !== issue_cyc + 1 + 8) begin
                miscompares++;
                $display("FAIL timeout_pulse: got %0d pulses first at %0d expected 1 at %0d",
                         err_n, err_first, issue_cyc + 9);
            end
            vectors++;
            if (busy_at_err !== 1'b0 || busy_last_wait !== 1'b1 || rsp_n !== 0) begin
                miscompares++;
                $display("FAIL timeout_abort: got busy %b/%b rsp %0d expected busy 1/0 rsp 0",
                         busy_last_wait, busy_at_err, rsp_n);
            end
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== (exp_rsp ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL timeout_last_grant: got %b expected %b", {req1_ready, req0_ready},
                     exp_rsp ? 2'b10 : 2'b01);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_backpressure;
        int cyc;
        apply_reset();
        enc_mode   = 2;
        enc_delay  = 1;
        enc_rand   = 0;
        req0_valid = 1'b1;
        req0_data  = 4'h9;
        rsp_ready  = 1'b0;
        cyc        = 1;
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
            req0_valid = 1'b0;
            req1_valid = 1'b1;
            req1_data  = 4'h5;
            #1;
            vectors++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_ready_busy: cycle %0d got %b expected 00", cyc,
                         {req1_ready, req0_ready});
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_code !== ham(4'h9) ||
                {req1_ready, req0_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v %b id %b code %h rdy %b expected v 1 id 0 code %h rdy 00",
                         i, rsp_valid, rsp_id, rsp_code, {req1_ready, req0_ready}, ham(4'h9));
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req1_ready, req0_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 010", {rsp_valid, req1_ready, req0_ready});
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_wait;
        int got, cyc, rsp_n, busy_n;
        apply_reset();
        enc_mode   = 2;
        enc_delay  = 6;
        enc_rand   = 0;
        req0_valid = 1'b1;
        req0_data  = 4'h2;
        rsp_ready  = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, rsp_valid, enc_valid, req1_ready, req0_ready, enc_data} !== 9'b0) begin
            miscompares++;
            $display("FAIL rstwait_async: got %b expected 0",
                     {busy, rsp_valid, enc_valid, req1_ready, req0_ready, enc_data});
        end
        @(negedge clk);
        rst    = 1'b1;
        rsp_n  = 0;
        busy_n = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (rsp_valid) rsp_n++;
            if (busy) busy_n++;
        end
        vectors++;
        if (rsp_n !== 0 || busy_n !== 0) begin
            miscompares++;
            $display("FAIL rstwait_stale: got rsp %0d busy %0d expected 0 0", rsp_n, busy_n);
        end
        clear_logs();
        words1.push_back(4'h7);
        enc_delay = 1;
        gap_en    = 0;
        rdy_pct   = 100;
        drive(1, 20, got, cyc);
        vectors++;
        if (got !== 1 || obs_id.size() < 1) begin
            miscompares++;
            $display("FAIL rstwait_next_count: got %0d expected 1", got);
        end else if (obs_id[0] !== 1'b1 || obs_code[0] !== ham(4'h7)) begin
            miscompares++;
            $display("FAIL rstwait_next: got id %b code %h expected id 1 code %h",
                     obs_id[0], obs_code[0], ham(4'h7));
        end
    endtask

    task automatic test_random;
        int got, cyc, n0, n1, i0, i1;
        logic last;
        logic exp_g;
        logic [3:0] m0[$], m1[$];
        logic [3:0] w;
        apply_reset();
        clear_logs();
        n0 = int'($urandom_range(3, 8));
        n1 = int'($urandom_range(3, 8));
        for (int i = 0; i < n0; i++) words0.push_back(4'($urandom));
        for (int i = 0; i < n1; i++) words1.push_back(4'($urandom));
        m0        = words0;
        m1        = words1;
        gap_en    = 1;
        rdy_pct   = 60;
        enc_mode  = 2;
        enc_rand  = 1;
        drive(n0 + n1, 2000, got, cyc);
        enc_rand = 0;
        vectors++;
        if (got !== n0 + n1 || acc_gnt.size() !== n0 + n1 || err_cnt !== 0) begin
            miscompares++;
            $display("FAIL random_count: got %0d rsp %0d acc %0d err expected %0d rsp 0 err",
                     got, acc_gnt.size(), err_cnt, n0 + n1);
        end
        last = 1'b1;
        i0   = 0;
        i1   = 0;
        for (int k = 0; k < acc_gnt.size() && k < obs_id.size(); k++) begin
            exp_g = (acc_mask[k] == 2'b11) ? !last : acc_mask[k][1];
            vectors++;
            if (acc_gnt[k] !== (exp_g ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL random_grant%0d: got %b expected %b (valids %b)", k, acc_gnt[k],
                         exp_g ? 2'b10 : 2'b01, acc_mask[k]);
            end
            if (exp_g) begin
                w = (i1 < m1.size()) ? m1[i1] : 4'h0;
                i1++;
            end else begin
                w = (i0 < m0.size()) ? m0[i0] : 4'h0;
                i0++;
            end
            vectors++;
            if (obs_id[k] !== exp_g || obs_code[k] !== ham(w)) begin
                miscompares++;
                $display("FAIL random_rsp%0d: got id %b code %h expected id %b code %h", k,
                         obs_id[k], obs_code[k], exp_g, ham(w));
            end
            last = exp_g;
        end
    endtask

    initial begin
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        rsp_ready  = 1'b0;
        enc_mode   = 0;
        enc_delay  = 1;
        enc_rand   = 0;
        enc_fixed  = '0;
        rdy_pct    = 100;
        gap_en     = 0;
        err_cnt    = 0;
        vld0       = 1'b0;
        vld1       = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_sustained();
        test_timeout(0, 0, 1'b0);
        test_timeout(2, 8, 1'b1);
        test_timeout(2, 9, 1'b0);
        test_backpressure();
        test_reset_wait();
        repeat (3) test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
